dmem_sram_bridge: RTL and testbench
===================================

Name: dmem_sram_bridge

Overview:
- Sits directly downstream of the pipeline's memory stage. It takes the M-stage data-memory request (enable, byte write mask, address, aligned write data) and drives an SRAM-like handshake bus (req / addr_ok / data_ok).
- It stalls the pipeline until the transaction completes.
- It holds read data stable while the rest of the pipeline is frozen by another stall source, such as the divider.
- It maps kseg0/kseg1 virtual addresses to physical.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAP_KSEG, 1, when 1, clear addr[31:29] for kseg0/kseg1 (addr[31:30]==2'b10); when 0, pass the address through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_en  in  1  M-stage instruction is a load/store.
- cpu_wen  in  4  byte write mask; 0 means read.
- cpu_size  in  2  0=byte, 1=half, 2=word.
- cpu_addr  in  ADDR_W  virtual address (aluoutM).
- cpu_wdata  in  DATA_W  lane-aligned store data (writedataM).
- pipe_stall_in  in  1  pipeline frozen by a stall source other than this block.
- cpu_rdata  out  DATA_W  read data for the W-stage register.
- cpu_stall  out  1  request pipeline freeze.
- data_req  out  1  bus request.
- data_wr  out  1  1=write.
- data_size  out  2  size code.
- data_addr  out  ADDR_W  physical address.
- data_wdata  out  DATA_W  write data.
- data_wstrb  out  4  byte strobe.
- data_addr_ok  in  1  slave accepted the request.
- data_data_ok  in  1  write completed or read data valid.
- data_rdata  in  DATA_W  read data.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - state = IDLE.
  - data_req = 0.
  - cpu_rdata = 0.
  - All latched request registers = 0.
  - cpu_stall = 0 whenever cpu_en = 0.
- States: IDLE, REQ, WAIT, DONE (2-bit encoding from package).
- IDLE:
  - If cpu_en: latch mapped addr, wdata, wen, size, and wr = |cpu_wen; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - data_req = 1; all bus outputs driven from the latched registers and stable until accepted.
  - addr_ok & data_ok in the same cycle: go to DONE, capturing rdata if a read.
  - addr_ok only: go to WAIT.
  - Neither: stay in REQ.
- WAIT:
  - data_req = 0.
  - On data_ok: if read, cpu_rdata <= data_rdata; go to DONE.
  - data_addr_ok is ignored in this state.
- DONE:
  - cpu_rdata is held.
  - pipe_stall_in = 1: stay in DONE and do not re-issue, even though cpu_en is still high.
  - pipe_stall_in = 0: the M stage advances this cycle; go to IDLE.
- cpu_stall = cpu_en & (state != DONE). It is combinational.
- Minimum latency: a zero-wait slave gives a 3-cycle stall-free turnaround (IDLE, REQ, DONE).
- Writes: cpu_rdata is unchanged.
- Reset mid-transaction: return to IDLE next edge; the bus response is discarded (the slave shares rst).
- data_ok outside WAIT/REQ is ignored.
- Stray data_addr_ok outside REQ is ignored.
- Address mapping is combinational on cpu_addr and registered at IDLE→REQ.
- Alignment checking is done upstream (the exception unit), not here.

Decomposition:
- Package mips_bus_pkg holds:
  - state encodings IDLE=0, REQ=1, WAIT=2, DONE=3;
  - size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the kseg region constants.
- One natural sub-module: kseg_addr_map, a combinational virtual-to-physical mapper parameterised by MAP_KSEG.

Test Plan:
- Load, zero-wait slave: cpu_en=1, wen=0, addr=0x8000_1004; slave asserts addr_ok and data_ok with rdata=0xDEAD_BEEF in the REQ cycle.
  - Expect data_addr=0x0000_1004, data_wr=0.
  - cpu_stall high for 2 cycles, then cpu_rdata=0xDEAD_BEEF.
- Store, delayed: wen=4'b0011, size=1, addr=0xA000_0010, wdata=0x0000_1234; addr_ok after 3 REQ cycles, data_ok 2 cycles later.
  - Expect data_req held high for 3 cycles with stable addr=0x0000_0010, wstrb=0011.
  - cpu_stall deasserts only in DONE.
  - cpu_rdata unchanged.
- Hold under external stall: load completes with rdata=0x1111_2222 while pipe_stall_in=1 for 4 cycles.
  - Expect state DONE for all 4 cycles, data_req=0 throughout (no re-issue), cpu_rdata stable, then IDLE.
- Back-to-back loads: two consecutive M-stage loads.
  - Expect exactly two data_req acceptances and distinct captured rdata.
  - Expect no gap beyond the IDLE cycle.
- Reset mid-op: assert rst while in WAIT.
  - Expect IDLE, data_req=0, cpu_rdata=0 at the next edge.
  - A late data_ok is ignored.
- MAP_KSEG=0: addr=0x8000_0000.
  - Expect data_addr=0x8000_0000.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared encodings for the M-stage data-memory bridge: FSM states, size codes,
// kseg region constants and the latched request control payload.
package mips_bus_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned SIZE_W     = 2;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned KSEG_TAG_W = 2;
    localparam int unsigned KSEG_CLR_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

    // addr[31:30] == 2'b10 selects kseg0 (0x8...) or kseg1 (0xA...)
    localparam logic [KSEG_TAG_W-1:0] KSEG01_TAG = 2'b10;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
    } req_ctrl_t;

endpackage

// File: rtl/dmem_sram_bridge_kseg_addr_map.sv
// Combinational virtual-to-physical mapper: kseg0/kseg1 addresses lose their
// top three bits; everything else passes through unchanged.
module kseg_addr_map
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAP_KSEG = 1
) (
    input  logic [ADDR_W-1:0] virt,
    output logic [ADDR_W-1:0] phys
);

    generate
        if (MAP_KSEG != 0) begin : g_map
            always_comb begin
                phys = virt;
                if (virt[ADDR_W-1 -: KSEG_TAG_W] == KSEG01_TAG) begin
                    phys[ADDR_W-1 -: KSEG_CLR_W] = '0;
                end
            end
        end else begin : g_pass
            assign phys = virt;
        end
    endgenerate

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage data-memory request to SRAM-like req/addr_ok/data_ok bridge; stalls
// the pipeline until completion and holds read data while frozen externally.
module dmem_sram_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAP_KSEG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [STRB_W-1:0] cpu_wen,
    input  logic [SIZE_W-1:0] cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              pipe_stall_in,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [STRB_W-1:0] data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              load_rdata;
    logic [ADDR_W-1:0] phys_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    req_ctrl_t         ctrl_q;

    kseg_addr_map #(
        .ADDR_W   (ADDR_W),
        .MAP_KSEG (MAP_KSEG)
    ) u_map (
        .virt (cpu_addr),
        .phys (phys_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE waits out foreign stalls so a still-high cpu_en is not re-issued
    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_en) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        load_rdata = ~ctrl_q.wr;
                        state_nxt  = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    load_rdata = ~ctrl_q.wr;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (!pipe_stall_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= '0;
            cpu_rdata <= '0;
            data_req  <= 1'b0;
        end else begin
            data_req <= (state_nxt == REQ);
            if (capture) begin
                addr_q  <= phys_addr;
                wdata_q <= cpu_wdata;
                ctrl_q  <= '{wr: |cpu_wen, size: cpu_size, wstrb: cpu_wen};
            end
            if (load_rdata) begin
                cpu_rdata <= data_rdata;
            end
        end
    end

    assign data_wr    = ctrl_q.wr;
    assign data_size  = ctrl_q.size;
    assign data_wstrb = ctrl_q.wstrb;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

    assign cpu_stall = cpu_en & (state != DONE);

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: table of single transfers against a
// zero-wait slave, plus hand sequences for delays, external stall and reset.
module tb_dmem_sram_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        pipe_stall_in;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [31:0] cpu_rdata, data_addr, data_wdata;
    logic        cpu_stall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;

    logic [31:0] d0_cpu_rdata, d0_data_addr, d0_data_wdata;
    logic        d0_cpu_stall, d0_data_req, d0_data_wr;
    logic [1:0]  d0_data_size;
    logic [3:0]  d0_data_wstrb;

    int n_chk   = 0;
    int n_fail  = 0;
    int acc_cnt = 0;

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAP_KSEG(1)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .pipe_stall_in(pipe_stall_in), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAP_KSEG(0)) dut0 (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .pipe_stall_in(pipe_stall_in), .cpu_rdata(d0_cpu_rdata),
        .cpu_stall(d0_cpu_stall), .data_req(d0_data_req), .data_wr(d0_data_wr),
        .data_size(d0_data_size), .data_addr(d0_data_addr),
        .data_wdata(d0_data_wdata), .data_wstrb(d0_data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && data_req && data_addr_ok) acc_cnt = acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One transfer against a zero-wait slave; DONE is held for 'hold' extra cycles.
    task automatic xfer(input vec_t v, input int hold);
        cpu_en        = 1'b1;
        cpu_addr      = v.addr;
        cpu_wen       = v.wen;
        cpu_size      = v.size;
        cpu_wdata     = v.wdata;
        pipe_stall_in = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(cpu_stall), 32'd1);
        chk("idle_req", 32'(data_req), 32'd0);
        next_cycle();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = v.rdata;
        @(negedge clk);
        chk("req_req", 32'(data_req), 32'd1);
        chk("req_addr", data_addr, v.exp_addr);
        chk("req_wr", 32'(data_wr), 32'(v.exp_wr));
        chk("req_wstrb", 32'(data_wstrb), 32'(v.wen));
        chk("req_size", 32'(data_size), 32'(v.size));
        if (v.exp_wr) chk("req_wdata", data_wdata, v.wdata);
        chk("req_stall", 32'(cpu_stall), 32'd1);
        chk("nomap_addr", d0_data_addr, v.addr);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = ~v.rdata;
        for (int h = 0; h <= hold; h++) begin
            pipe_stall_in = (h < hold);
            @(negedge clk);
            chk("done_stall", 32'(cpu_stall), 32'd0);
            chk("done_req", 32'(data_req), 32'd0);
            chk("done_rdata", cpu_rdata, v.exp_rdata);
            next_cycle();
        end
        pipe_stall_in = 1'b0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'h0;
    endtask

    vec_t vecs[8];
    vec_t v;
    int   acc0;

    initial begin
        vecs[0] = '{32'h8000_1004, 4'h0, 2'd2, 32'h0,         32'hDEAD_BEEF, 32'h0000_1004, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'hA000_0010, 4'h3, 2'd1, 32'h0000_1234, 32'h5555_5555, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{32'h0040_0020, 4'h0, 2'd2, 32'h0,         32'h1234_5678, 32'h0040_0020, 1'b0, 32'h1234_5678};
        vecs[3] = '{32'hBFC0_0008, 4'h0, 2'd2, 32'h0,         32'hCAFE_F00D, 32'h1FC0_0008, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{32'hC000_0003, 4'h8, 2'd0, 32'hAB00_0000, 32'h0000_0000, 32'hC000_0003, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{32'h8000_0000, 4'h0, 2'd2, 32'h0,         32'h0BAD_CAFE, 32'h0000_0000, 1'b0, 32'h0BAD_CAFE};
        vecs[6] = '{32'h9FFF_FFFC, 4'h0, 2'd2, 32'h0,         32'h0F0F_0F0F, 32'h1FFF_FFFC, 1'b0, 32'h0F0F_0F0F};
        vecs[7] = '{32'h7FFF_FFFC, 4'h0, 2'd2, 32'h0,         32'h1357_9BDF, 32'h7FFF_FFFC, 1'b0, 32'h1357_9BDF};

        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_size = 2'd0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; pipe_stall_in = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        foreach (vecs[i]) begin
            xfer(vecs[i], 0);
            cpu_en = 1'b0;
            @(negedge clk);
            chk("gap_stall", 32'(cpu_stall), 32'd0);
            next_cycle();
        end

        // Store with three REQ cycles, then a two-cycle WAIT with a stray addr_ok
        cpu_en = 1'b1; cpu_addr = 32'hA000_0010; cpu_wen = 4'b0011;
        cpu_size = 2'd1; cpu_wdata = 32'h0000_1234;
        @(negedge clk);
        chk("dst_idle_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            data_addr_ok = (i == 2);
            @(negedge clk);
            chk("dst_req", 32'(data_req), 32'd1);
            chk("dst_addr", data_addr, 32'h0000_0010);
            chk("dst_wstrb", 32'(data_wstrb), 32'h3);
            chk("dst_wdata", data_wdata, 32'h0000_1234);
            chk("dst_stall", 32'(cpu_stall), 32'd1);
            next_cycle();
        end
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("dst_wait_req", 32'(data_req), 32'd0);
        chk("dst_wait_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("dst_wait2_req", 32'(data_req), 32'd0);
        chk("dst_wait2_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("dst_done_stall", 32'(cpu_stall), 32'd0);
        chk("dst_rdata", cpu_rdata, 32'h1357_9BDF);
        next_cycle();
        cpu_en = 1'b0;
        next_cycle();

        // Load held four cycles under an external stall, then two back-to-back loads
        acc0 = acc_cnt;
        v = '{32'h0000_0080, 4'h0, 2'd2, 32'h0, 32'h1111_2222, 32'h0000_0080, 1'b0, 32'h1111_2222};
        xfer(v, 4);
        v = '{32'h0000_0100, 4'h0, 2'd2, 32'h0, 32'hAAAA_0001, 32'h0000_0100, 1'b0, 32'hAAAA_0001};
        xfer(v, 0);
        v = '{32'h8000_0104, 4'h0, 2'd2, 32'h0, 32'hBBBB_0002, 32'h0000_0104, 1'b0, 32'hBBBB_0002};
        xfer(v, 0);
        cpu_en = 1'b0;
        next_cycle();
        chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);

        // Reset while waiting for data_ok; the late response must be dropped
        cpu_en = 1'b1; cpu_addr = 32'h8000_0200; cpu_wen = 4'h0; cpu_size = 2'd2;
        next_cycle();
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rmo_req", 32'(data_req), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rmo_wait_req", 32'(data_req), 32'd0);
        chk("rmo_wait_stall", 32'(cpu_stall), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; cpu_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rmo_req_after", 32'(data_req), 32'd0);
        chk("rmo_rdata_after", cpu_rdata, 32'd0);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("rmo_late_ok_rdata", cpu_rdata, 32'd0);
        next_cycle();
        v = '{32'h8000_0200, 4'h0, 2'd2, 32'h0, 32'h2468_ACE0, 32'h0000_0200, 1'b0, 32'h2468_ACE0};
        xfer(v, 0);
        cpu_en = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
